mem_arbiter: RTL

- Owns the single CPU memory port and shares it between the instruction fetcher, the execute unit (load/store) and a built-in OAM DMA sequencer (write to $4014).
- Performs one memory access per cycle.
- Fetch and exec are arbitrated round-robin.
- While OAM DMA is active, the sequencer locks out both CPU requesters.

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_oam_dma_seq.sv | 77 +++++++
 rtl/mem_arbiter.sv | 105 ++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU memory-port arbiter slice.
//   - default widths, OAM data register address and DMA transfer length
//   - DMA sequencer state type and round-robin requester identifier
package mem_arbiter_pkg;

  localparam int unsigned       ARB_ADDR_WIDTH    = 16;
  localparam int unsigned       ARB_REG_WIDTH     = 8;
  localparam logic [15:0]       ARB_OAM_DATA_ADDR = 16'h2004;
  localparam int unsigned       ARB_DMA_LEN       = 256;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_HALT,
    ARB_ALIGN,
    ARB_READ,
    ARB_WRITE
  } arb_state_t;

  typedef enum logic {
    SRC_FETCH,
    SRC_EXEC
  } src_t;

endpackage

// File: rtl/mem_arbiter_oam_dma_seq.sv
// OAM DMA sequencer: copies DMA_LEN bytes from page {dma_page, 00..} to the
// OAM data register, one read and one write per byte.
//   clk, reset_n        clock, asynchronous active-low reset
//   dma_start, dma_page start pulse (honoured only when idle) and source page
//   dma_busy            transfer in progress (HALT through final WRITE)
//   dma_re, dma_we      memory strobes requested by the sequencer
//   dma_addr            memory address for the current sequencer access
module oam_dma_seq
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = ARB_ADDR_WIDTH,
  parameter int unsigned           REG_WIDTH     = ARB_REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ARB_OAM_DATA_ADDR,
  parameter int unsigned           DMA_LEN       = ARB_DMA_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  dma_start,
  input  logic [REG_WIDTH-1:0]  dma_page,
  output logic                  dma_busy,
  output logic                  dma_re,
  output logic                  dma_we,
  output logic [ADDR_WIDTH-1:0] dma_addr
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  arb_state_t           state_q, state_d;
  logic [7:0]           idx_q;
  logic [REG_WIDTH-1:0] page_q;
  logic                 parity_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      idx_q    <= '0;
      page_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      parity_q <= ~parity_q;
      if (state_q == ARB_IDLE && dma_start) begin
        page_q <= dma_page;
        idx_q  <= '0;
      end else if (state_q == ARB_WRITE) begin
        idx_q <= idx_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    dma_re   = 1'b0;
    dma_we   = 1'b0;
    dma_addr = '0;
    unique case (state_q)
      ARB_IDLE:  if (dma_start) state_d = ARB_HALT;
      // An odd cycle in HALT costs one extra ALIGN cycle before the first read.
      ARB_HALT:  state_d = parity_q ? ARB_ALIGN : ARB_READ;
      ARB_ALIGN: state_d = ARB_READ;
      ARB_READ: begin
        dma_re   = 1'b1;
        dma_addr = ADDR_WIDTH'({page_q, idx_q});
        state_d  = ARB_WRITE;
      end
      ARB_WRITE: begin
        dma_we   = 1'b1;
        dma_addr = OAM_DATA_ADDR;
        state_d  = (idx_q == LAST_IDX) ? ARB_IDLE : ARB_READ;
      end
      default:   state_d = ARB_IDLE;
    endcase
  end

  assign dma_busy = (state_q != ARB_IDLE);

endmodule

// File: rtl/mem_arbiter.sv
// Single CPU memory port shared by the instruction fetcher, the execute unit
// and the OAM DMA sequencer; one access per cycle.
//   fetch_*  fetcher read requests, grant and read-valid
//   exec_*   execute unit load/store requests, grant and read-valid
//   dma_*    OAM DMA start/page and busy indication
//   mem_*    memory port (combinational address/strobes, rdata next cycle)
//   rdata    mem_rdata passed through to whichever requester has rvalid
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH    = ARB_ADDR_WIDTH,
  parameter int unsigned           REG_WIDTH     = ARB_REG_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = ARB_OAM_DATA_ADDR,
  parameter int unsigned           DMA_LEN       = ARB_DMA_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  input  logic                  exec_req,
  input  logic                  exec_we,
  input  logic [ADDR_WIDTH-1:0] exec_addr,
  input  logic [REG_WIDTH-1:0]  exec_wdata,
  output logic                  exec_gnt,
  output logic                  exec_rvalid,
  input  logic                  dma_start,
  input  logic [REG_WIDTH-1:0]  dma_page,
  output logic                  dma_busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [REG_WIDTH-1:0]  mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [REG_WIDTH-1:0]  mem_rdata,
  output logic [REG_WIDTH-1:0]  rdata
);

  src_t                  last_gnt;
  logic                  dma_re;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;

  oam_dma_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .REG_WIDTH     (REG_WIDTH),
    .OAM_DATA_ADDR (OAM_DATA_ADDR),
    .DMA_LEN       (DMA_LEN)
  ) u_dma (
    .clk       (clk),
    .reset_n   (reset_n),
    .dma_start (dma_start),
    .dma_page  (dma_page),
    .dma_busy  (dma_busy),
    .dma_re    (dma_re),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr)
  );

  // Port outputs are combinational; reset_n gates them so nothing reaches
  // memory while reset is held, even with requests asserted.
  always_comb begin
    fetch_gnt = 1'b0;
    exec_gnt  = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset_n) begin
      if (dma_busy) begin
        mem_re   = dma_re;
        mem_we   = dma_we;
        mem_addr = dma_addr;
        // DMA write data is the byte read in the preceding READ cycle.
        if (dma_we) mem_wdata = mem_rdata;
      end else if (fetch_req && (!exec_req || last_gnt == SRC_EXEC)) begin
        fetch_gnt = 1'b1;
        mem_re    = 1'b1;
        mem_addr  = fetch_addr;
      end else if (exec_req) begin
        exec_gnt = 1'b1;
        mem_we   = exec_we;
        mem_re   = ~exec_we;
        mem_addr = exec_addr;
        if (exec_we) mem_wdata = exec_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_gnt     <= SRC_EXEC;
      fetch_rvalid <= 1'b0;
      exec_rvalid  <= 1'b0;
    end else begin
      fetch_rvalid <= fetch_gnt;
      exec_rvalid  <= exec_gnt & ~exec_we;
      if (fetch_gnt)     last_gnt <= SRC_FETCH;
      else if (exec_gnt) last_gnt <= SRC_EXEC;
    end
  end

  assign rdata = mem_rdata;

endmodule
